// File: rtl/wb_pkg.sv
// Shared types for the writeback commit queue.
// Entry payload layout and register constants.
package wb_pkg;

    localparam int WB_XLEN = 32;
    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic                wr_reg;
        logic                rd_is_x1;
        logic                rd_is_xn;
        logic                wr_csrreg;
        logic                exp;
        logic [4:0]          regindex;
        logic [WB_XLEN-1:0]  wdata;
        logic [11:0]         csrindex;
        logic [WB_XLEN-1:0]  csrwdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic in-order entry storage with push, pop and flush.
// Exposes every slot and its occupancy for scoreboarding.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic [W-1:0]  slots [DEPTH],
    output logic [DEPTH-1:0] vld
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [PW-1:0] off;

    assign do_push = push & (count != CW'(DEPTH));
    assign do_pop  = pop & (count != '0);
    assign head    = mem[rd_ptr];
    assign slots   = mem;

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        vld = '0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            vld[i] = (CW'(off) < count);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/wb_commit_q.sv
// In-order writeback commit queue with CSR stall, trap flush
// and a pending-GPR-write scoreboard for decode.
module wb_commit_q
    import wb_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem2wb_valid,
    output logic             mem2wb_ready,
    input  logic             mem2wb_wr_reg,
    input  logic             mem2wb_rd_is_x1,
    input  logic             mem2wb_rd_is_xn,
    input  logic             mem2wb_wr_csrreg,
    input  logic             mem2wb_exp,
    input  logic [4:0]       mem2wb_wr_regindex,
    input  logic [XLEN-1:0]  mem2wb_wr_wdata,
    input  logic [XLEN-1:0]  mem2wb_wr_csrwdata,
    input  logic [11:0]      mem2wb_wr_csrindex,
    input  logic             interrupt,
    input  logic             csrfile_ready,
    output logic             wb2regfile_wr_reg,
    output logic [4:0]       wb2regfile_wr_regindex,
    output logic [XLEN-1:0]  wb2regfile_wr_wdata,
    output logic             wb2regfile_rd_is_x1,
    output logic             wb2regfile_rd_is_xn,
    output logic             wb2csrfile_wr_reg,
    output logic [11:0]      wb2csrfile_wr_regindex,
    output logic [XLEN-1:0]  wb2csrfile_wr_wdata,
    output logic             wb2ctrl_trap,
    output logic [31:0]      wb_pending_mask
);

    localparam int W = $bits(wb_entry_t);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t       din;
    wb_entry_t       head;
    wb_entry_t       se;
    logic [W-1:0]    head_bits;
    logic [W-1:0]    slots [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [CW-1:0]   count;
    logic            head_valid;
    logic            trap;
    logic            retire;
    logic            push;

    assign din.wr_reg    = mem2wb_wr_reg;
    assign din.rd_is_x1  = mem2wb_rd_is_x1;
    assign din.rd_is_xn  = mem2wb_rd_is_xn;
    assign din.wr_csrreg = mem2wb_wr_csrreg;
    assign din.exp       = mem2wb_exp;
    assign din.regindex  = mem2wb_wr_regindex;
    assign din.wdata     = mem2wb_wr_wdata;
    assign din.csrindex  = mem2wb_wr_csrindex;
    assign din.csrwdata  = mem2wb_wr_csrwdata;

    assign head_valid = (count != '0);
    assign head = head_valid ? wb_entry_t'(head_bits) : '0;
    assign trap = head_valid & (head.exp | interrupt);
    assign retire = head_valid & ~trap & (~head.wr_csrreg | csrfile_ready);

    // A trapping head squashes everything younger, including this cycle's offer.
    assign mem2wb_ready = (count != CW'(DEPTH));
    assign push = mem2wb_valid & mem2wb_ready & ~trap;

    wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (retire),
        .flush (trap),
        .din   (din),
        .head  (head_bits),
        .count (count),
        .slots (slots),
        .vld   (vld)
    );

    assign wb2regfile_wr_reg      = retire & head.wr_reg & (head.regindex != REG_X0);
    assign wb2regfile_wr_regindex = head.regindex;
    assign wb2regfile_wr_wdata    = head.wdata;
    assign wb2regfile_rd_is_x1    = head.rd_is_x1;
    assign wb2regfile_rd_is_xn    = head.rd_is_xn;
    assign wb2csrfile_wr_reg      = retire & head.wr_csrreg;
    assign wb2csrfile_wr_regindex = head.csrindex;
    assign wb2csrfile_wr_wdata    = head.csrwdata;
    assign wb2ctrl_trap           = trap;

    always_comb begin
        wb_pending_mask = '0;
        se = '0;
        for (int s = 0; s < DEPTH; s++) begin
            se = wb_entry_t'(slots[s]);
            if (vld[s] & se.wr_reg) wb_pending_mask[se.regindex] = 1'b1;
        end
        wb_pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_commit_q.sv
// Directed self-checking bench for wb_commit_q.
// Inputs change on the falling edge; outputs are checked #1 later.
module tb_wb_commit_q;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem2wb_valid = 1'b0;
    logic        mem2wb_ready;
    logic        mem2wb_wr_reg = 1'b0;
    logic        mem2wb_rd_is_x1 = 1'b0;
    logic        mem2wb_rd_is_xn = 1'b0;
    logic        mem2wb_wr_csrreg = 1'b0;
    logic        mem2wb_exp = 1'b0;
    logic [4:0]  mem2wb_wr_regindex = '0;
    logic [31:0] mem2wb_wr_wdata = '0;
    logic [31:0] mem2wb_wr_csrwdata = '0;
    logic [11:0] mem2wb_wr_csrindex = '0;
    logic        interrupt = 1'b0;
    logic        csrfile_ready = 1'b1;
    logic        wb2regfile_wr_reg;
    logic [4:0]  wb2regfile_wr_regindex;
    logic [31:0] wb2regfile_wr_wdata;
    logic        wb2regfile_rd_is_x1;
    logic        wb2regfile_rd_is_xn;
    logic        wb2csrfile_wr_reg;
    logic [11:0] wb2csrfile_wr_regindex;
    logic [31:0] wb2csrfile_wr_wdata;
    logic        wb2ctrl_trap;
    logic [31:0] wb_pending_mask;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_commit_q #(.XLEN(32), .DEPTH(4)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .mem2wb_valid           (mem2wb_valid),
        .mem2wb_ready           (mem2wb_ready),
        .mem2wb_wr_reg          (mem2wb_wr_reg),
        .mem2wb_rd_is_x1        (mem2wb_rd_is_x1),
        .mem2wb_rd_is_xn        (mem2wb_rd_is_xn),
        .mem2wb_wr_csrreg       (mem2wb_wr_csrreg),
        .mem2wb_exp             (mem2wb_exp),
        .mem2wb_wr_regindex     (mem2wb_wr_regindex),
        .mem2wb_wr_wdata        (mem2wb_wr_wdata),
        .mem2wb_wr_csrwdata     (mem2wb_wr_csrwdata),
        .mem2wb_wr_csrindex     (mem2wb_wr_csrindex),
        .interrupt              (interrupt),
        .csrfile_ready          (csrfile_ready),
        .wb2regfile_wr_reg      (wb2regfile_wr_reg),
        .wb2regfile_wr_regindex (wb2regfile_wr_regindex),
        .wb2regfile_wr_wdata    (wb2regfile_wr_wdata),
        .wb2regfile_rd_is_x1    (wb2regfile_rd_is_x1),
        .wb2regfile_rd_is_xn    (wb2regfile_rd_is_xn),
        .wb2csrfile_wr_reg      (wb2csrfile_wr_reg),
        .wb2csrfile_wr_regindex (wb2csrfile_wr_regindex),
        .wb2csrfile_wr_wdata    (wb2csrfile_wr_wdata),
        .wb2ctrl_trap           (wb2ctrl_trap),
        .wb_pending_mask        (wb_pending_mask)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one offer on the falling edge and settle.
    task automatic offer(input logic v, input logic wr, input logic [4:0] idx,
                         input logic [31:0] wd, input logic csr,
                         input logic [11:0] cidx, input logic [31:0] cwd,
                         input logic ex);
        @(negedge clk);
        mem2wb_valid       = v;
        mem2wb_wr_reg      = wr;
        mem2wb_wr_regindex = idx;
        mem2wb_wr_wdata    = wd;
        mem2wb_wr_csrreg   = csr;
        mem2wb_wr_csrindex = cidx;
        mem2wb_wr_csrwdata = cwd;
        mem2wb_exp         = ex;
        #1;
    endtask

    task automatic idle();
        offer(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 12'h0, 32'h0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, mem2wb_ready, 1);
        check({tag, "_gpr_we"}, wb2regfile_wr_reg, 0);
        check({tag, "_gpr_idx"}, wb2regfile_wr_regindex, 0);
        check({tag, "_gpr_wd"}, wb2regfile_wr_wdata, 0);
        check({tag, "_x1xn"}, {wb2regfile_rd_is_x1, wb2regfile_rd_is_xn}, 0);
        check({tag, "_csr_we"}, wb2csrfile_wr_reg, 0);
        check({tag, "_csr_idx"}, wb2csrfile_wr_regindex, 0);
        check({tag, "_csr_wd"}, wb2csrfile_wr_wdata, 0);
        check({tag, "_trap"}, wb2ctrl_trap, 0);
        check({tag, "_mask"}, wb_pending_mask, 0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Three GPR entries retire back to back; x0 never writes.
        offer(1, 1, 5'd5, 32'h11, 0, 12'h0, 32'h0, 0);
        offer(1, 1, 5'd6, 32'h22, 0, 12'h0, 32'h0, 0);
        check("x5_we", wb2regfile_wr_reg, 1);
        check("x5_idx", wb2regfile_wr_regindex, 5);
        check("x5_wd", wb2regfile_wr_wdata, 32'h11);
        check("x5_mask", wb_pending_mask, 32'h20);
        offer(1, 1, 5'd0, 32'h33, 0, 12'h0, 32'h0, 0);
        check("x6_we", wb2regfile_wr_reg, 1);
        check("x6_idx", wb2regfile_wr_regindex, 6);
        check("x6_wd", wb2regfile_wr_wdata, 32'h22);
        check("x6_mask", wb_pending_mask, 32'h40);
        idle();
        check("x0_we", wb2regfile_wr_reg, 0);
        check("x0_wd", wb2regfile_wr_wdata, 32'h33);
        check("x0_mask", wb_pending_mask, 0);
        idle();
        check_all_zero("drain1");

        // Fill behind a stalled CSR head; fifth offer is refused.
        csrfile_ready = 1'b0;
        offer(1, 0, 5'd0, 32'h0, 1, 12'h300, 32'hDEAD, 0);
        offer(1, 1, 5'd1, 32'hA1, 0, 12'h0, 32'h0, 0);
        check("stall_csr_we", wb2csrfile_wr_reg, 0);
        offer(1, 1, 5'd2, 32'hA2, 0, 12'h0, 32'h0, 0);
        offer(1, 1, 5'd3, 32'hA3, 0, 12'h0, 32'h0, 0);
        offer(1, 1, 5'd7, 32'h77, 0, 12'h0, 32'h0, 0);
        check("full_ready", mem2wb_ready, 0);
        check("full_gpr_we", wb2regfile_wr_reg, 0);
        idle();
        check("full_ready2", mem2wb_ready, 0);
        check("full_mask", wb_pending_mask, 32'h0E);
        csrfile_ready = 1'b1;
        #1;
        check("csr_we", wb2csrfile_wr_reg, 1);
        check("csr_idx", wb2csrfile_wr_regindex, 12'h300);
        check("csr_wd", wb2csrfile_wr_wdata, 32'hDEAD);
        check("csr_gpr_we", wb2regfile_wr_reg, 0);
        idle();
        csrfile_ready = 1'b0;
        #1;
        check("after_csr_ready", mem2wb_ready, 1);
        check("after_csr_head", wb2regfile_wr_regindex, 1);
        csrfile_ready = 1'b1;
        idle();
        check("drain2_x2", wb2regfile_wr_wdata, 32'hA2);
        idle();
        check("drain2_x3", wb2regfile_wr_wdata, 32'hA3);
        idle();
        check("drain2_empty", wb_pending_mask, 0);

        // Excepting head with two younger entries plus a same-cycle offer.
        csrfile_ready = 1'b0;
        offer(1, 0, 5'd0, 32'h0, 1, 12'h301, 32'hBEEF, 0);
        offer(1, 1, 5'd9, 32'h99, 0, 12'h0, 32'h0, 1);
        offer(1, 1, 5'd10, 32'hAA, 0, 12'h0, 32'h0, 0);
        offer(1, 1, 5'd11, 32'hBB, 0, 12'h0, 32'h0, 0);
        idle();
        csrfile_ready = 1'b1;
        #1;
        check("pre_trap_csr_we", wb2csrfile_wr_reg, 1);
        check("pre_trap_csr_idx", wb2csrfile_wr_regindex, 12'h301);
        offer(1, 1, 5'd12, 32'hCC, 0, 12'h0, 32'h0, 0);
        check("trap_pulse", wb2ctrl_trap, 1);
        check("trap_gpr_we", wb2regfile_wr_reg, 0);
        check("trap_csr_we", wb2csrfile_wr_reg, 0);
        check("trap_mask", wb_pending_mask, 32'h0E00);
        idle();
        check("post_trap", wb2ctrl_trap, 0);
        check("post_trap_mask", wb_pending_mask, 0);
        check("post_trap_empty", wb2regfile_wr_regindex, 0);
        check("post_trap_we", wb2regfile_wr_reg, 0);
        check("post_trap_ready", mem2wb_ready, 1);

        // Interrupt squashes a CSR-stalled head; empty queue ignores it.
        csrfile_ready = 1'b0;
        offer(1, 0, 5'd0, 32'h0, 1, 12'h305, 32'h55, 0);
        idle();
        check("irq_stall_csr_we", wb2csrfile_wr_reg, 0);
        check("irq_stall_trap", wb2ctrl_trap, 0);
        interrupt = 1'b1;
        #1;
        check("irq_trap", wb2ctrl_trap, 1);
        check("irq_csr_we", wb2csrfile_wr_reg, 0);
        idle();
        check("irq_empty_trap", wb2ctrl_trap, 0);
        check("irq_empty_csr_we", wb2csrfile_wr_reg, 0);
        interrupt = 1'b0;
        csrfile_ready = 1'b1;

        // Streaming 20 entries wraps the pointers several times.
        for (int i = 0; i <= 20; i++) begin
            if (i < 20)
                offer(1, 1, 5'((i % 31) + 1), 32'h1000 + 32'(i), 0, 12'h0, 32'h0, 0);
            else
                idle();
            if (i > 0) begin
                check($sformatf("stream%0d_we", i - 1), wb2regfile_wr_reg, 1);
                check($sformatf("stream%0d_idx", i - 1), wb2regfile_wr_regindex,
                      64'(((i - 1) % 31) + 1));
                check($sformatf("stream%0d_wd", i - 1), wb2regfile_wr_wdata,
                      64'(32'h1000 + 32'(i - 1)));
            end
        end
        idle();
        check("stream_empty", wb2regfile_wr_reg, 0);

        // Reset in the middle of a stalled queue.
        csrfile_ready = 1'b0;
        offer(1, 0, 5'd0, 32'h0, 1, 12'h310, 32'h1234, 0);
        offer(1, 1, 5'd4, 32'h44, 0, 12'h0, 32'h0, 0);
        offer(1, 1, 5'd5, 32'h45, 0, 12'h0, 32'h0, 0);
        idle();
        check("pre_rst_mask", wb_pending_mask, 32'h30);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        csrfile_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            check($sformatf("postrst%0d_gpr", i), wb2regfile_wr_reg, 0);
            check($sformatf("postrst%0d_csr", i), wb2csrfile_wr_reg, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
